// File: rtl/cpu_0_oci_pkg.sv
// Shared types and constants for the OCI access arbiter: opcodes, FSM states,
// JTAG command entry layout and the strobe-to-opcode priority encoder.
package cpu_0_oci_pkg;

    localparam int PAYLOAD_W = 38;
    localparam int ENTRY_W   = 42;

    localparam logic [3:0] OP_BREAK_A    = 4'd1;
    localparam logic [3:0] OP_BREAK_B    = 4'd2;
    localparam logic [3:0] OP_BREAK_C    = 4'd3;
    localparam logic [3:0] OP_OCIMEM_A   = 4'd4;
    localparam logic [3:0] OP_OCIMEM_B   = 4'd5;
    localparam logic [3:0] OP_TRACECTRL  = 4'd6;
    localparam logic [3:0] OP_TRACEMEM_A = 4'd7;
    localparam logic [3:0] OP_TRACEMEM_B = 4'd8;

    localparam logic SRC_JTAG = 1'b0;
    localparam logic SRC_CPU  = 1'b1;

    typedef enum logic {IDLE, BUSY} state_t;

    typedef struct packed {
        logic [3:0]           op;
        logic [PAYLOAD_W-1:0] data;
    } cmd_t;

    // Strobe bit i carries opcode i+1; the lowest set bit wins.
    function automatic logic [3:0] lowest_op(input logic [7:0] s);
        logic [3:0] op;
        op = '0;
        for (int i = 7; i >= 0; i--) begin
            if (s[i]) op = 4'(i + 1);
        end
        return op;
    endfunction

endpackage

// File: rtl/cpu_0_oci_cmd_fifo.sv
// JTAG command queue: synchronous FIFO that accepts a push while full when
// the head is being popped in the same cycle.
module cpu_0_oci_cmd_fifo
    import cpu_0_oci_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic push,
    input  logic pop,
    input  cmd_t din,
    output cmd_t dout,
    output logic full,
    output logic empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    cmd_t           mem [DEPTH];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic [AW:0]    count;
    logic           wr_en;
    logic           rd_en;

    assign full  = (count == (AW + 1)'(DEPTH));
    assign empty = (count == '0);
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cpu_0_oci_access_arbiter.sv
// Shares the OCI port between queued JTAG commands and CPU monitor requests
// with round-robin arbitration, req/ack handshake and a watchdog abort.
module cpu_0_oci_access_arbiter
    import cpu_0_oci_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [PAYLOAD_W-1:0] jdo,
    input  logic                 take_action_break_a,
    input  logic                 take_action_break_b,
    input  logic                 take_action_break_c,
    input  logic                 take_action_ocimem_a,
    input  logic                 take_action_ocimem_b,
    input  logic                 take_action_tracectrl,
    input  logic                 take_action_tracemem_a,
    input  logic                 take_action_tracemem_b,
    input  logic                 cpu_req,
    input  logic [3:0]           cpu_op,
    input  logic [PAYLOAD_W-1:0] cpu_data,
    output logic                 cpu_gnt,
    output logic                 oci_req,
    output logic [3:0]           oci_op,
    output logic [PAYLOAD_W-1:0] oci_data,
    output logic                 oci_src,
    input  logic                 oci_ack,
    input  logic                 oci_err,
    output logic                 done_jtag,
    output logic                 done_cpu,
    output logic                 done_err,
    output logic                 cmd_overflow,
    output logic                 timeout_err,
    input  logic                 clear_err
);

    logic [7:0] strobes;
    logic       push;
    logic       multi;
    logic       pop;
    logic       full;
    logic       empty;
    cmd_t       fifo_in;
    cmd_t       fifo_out;

    assign strobes = {take_action_tracemem_b, take_action_tracemem_a, take_action_tracectrl,
                      take_action_ocimem_b, take_action_ocimem_a,
                      take_action_break_c, take_action_break_b, take_action_break_a};
    assign push    = |strobes;
    assign multi   = |(strobes & (strobes - 8'd1));
    assign fifo_in = '{op: lowest_op(strobes), data: jdo};

    cpu_0_oci_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .din     (fifo_in),
        .dout    (fifo_out),
        .full    (full),
        .empty   (empty)
    );

    state_t               state, state_nx;
    logic                 last_src, last_src_nx;
    logic [7:0]           wd, wd_nx;
    logic                 req_nx, src_nx, gnt_nx;
    logic [3:0]           op_nx;
    logic [PAYLOAD_W-1:0] data_nx;
    logic                 done_jtag_nx, done_cpu_nx, done_err_nx;
    logic                 timeout_set;
    logic                 pick_cpu;

    always_comb begin
        state_nx     = state;
        last_src_nx  = last_src;
        wd_nx        = wd;
        req_nx       = oci_req;
        op_nx        = oci_op;
        data_nx      = oci_data;
        src_nx       = oci_src;
        gnt_nx       = 1'b0;
        done_jtag_nx = 1'b0;
        done_cpu_nx  = 1'b0;
        done_err_nx  = 1'b0;
        timeout_set  = 1'b0;
        pop          = 1'b0;
        pick_cpu     = cpu_req && (empty || last_src == SRC_JTAG);
        case (state)
            IDLE: begin
                if (!empty || cpu_req) begin
                    if (pick_cpu) begin
                        op_nx   = cpu_op;
                        data_nx = cpu_data;
                        src_nx  = SRC_CPU;
                        gnt_nx  = 1'b1;
                    end else begin
                        op_nx   = fifo_out.op;
                        data_nx = fifo_out.data;
                        src_nx  = SRC_JTAG;
                        pop     = 1'b1;
                    end
                    req_nx      = 1'b1;
                    last_src_nx = pick_cpu;
                    wd_nx       = '0;
                    state_nx    = BUSY;
                end
            end
            BUSY: begin
                if (oci_ack || wd == 8'(TIMEOUT)) begin
                    req_nx       = 1'b0;
                    done_jtag_nx = (oci_src == SRC_JTAG);
                    done_cpu_nx  = (oci_src == SRC_CPU);
                    done_err_nx  = oci_ack ? oci_err : 1'b1;
                    timeout_set  = !oci_ack;
                    state_nx     = IDLE;
                end else if (wd != 8'hFF) begin
                    wd_nx = wd + 8'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            last_src  <= SRC_CPU;
            wd        <= '0;
            oci_req   <= 1'b0;
            oci_op    <= '0;
            oci_data  <= '0;
            oci_src   <= 1'b0;
            cpu_gnt   <= 1'b0;
            done_jtag <= 1'b0;
            done_cpu  <= 1'b0;
            done_err  <= 1'b0;
        end else begin
            state     <= state_nx;
            last_src  <= last_src_nx;
            wd        <= wd_nx;
            oci_req   <= req_nx;
            oci_op    <= op_nx;
            oci_data  <= data_nx;
            oci_src   <= src_nx;
            cpu_gnt   <= gnt_nx;
            done_jtag <= done_jtag_nx;
            done_cpu  <= done_cpu_nx;
            done_err  <= done_err_nx;
        end
    end

    // A clear in the same cycle as a new event wins; the event is lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_overflow <= 1'b0;
            timeout_err  <= 1'b0;
        end else if (clear_err) begin
            cmd_overflow <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            if (multi || (push && full && !pop)) cmd_overflow <= 1'b1;
            if (timeout_set)                     timeout_err  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cpu_0_oci_access_arbiter.sv
// Directed bench: expected OCI transactions queued as stimulus is driven and
// checked when the arbiter issues them.
module tb_cpu_0_oci_access_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [37:0] jdo = '0;
    logic [7:0]  ta = '0;
    logic        cpu_req = 1'b0;
    logic [3:0]  cpu_op = '0;
    logic [37:0] cpu_data = '0;
    logic        cpu_gnt, oci_req, oci_src;
    logic [3:0]  oci_op;
    logic [37:0] oci_data;
    logic        oci_ack = 1'b0, oci_err = 1'b0;
    logic        done_jtag, done_cpu, done_err, cmd_overflow, timeout_err;
    logic        clear_err = 1'b0;

    int n_chk = 0;
    int n_fail = 0;
    int gnt_cnt = 0;
    int done_cnt = 0;
    int req_cnt = 0;
    logic [42:0] exp_q[$];

    always #5 clk = ~clk;

    cpu_0_oci_access_arbiter #(.FIFO_DEPTH(4), .TIMEOUT(255)) dut (
        .clk(clk), .reset_n(reset_n), .jdo(jdo),
        .take_action_break_a(ta[0]), .take_action_break_b(ta[1]), .take_action_break_c(ta[2]),
        .take_action_ocimem_a(ta[3]), .take_action_ocimem_b(ta[4]),
        .take_action_tracectrl(ta[5]), .take_action_tracemem_a(ta[6]),
        .take_action_tracemem_b(ta[7]),
        .cpu_req(cpu_req), .cpu_op(cpu_op), .cpu_data(cpu_data), .cpu_gnt(cpu_gnt),
        .oci_req(oci_req), .oci_op(oci_op), .oci_data(oci_data), .oci_src(oci_src),
        .oci_ack(oci_ack), .oci_err(oci_err), .done_jtag(done_jtag), .done_cpu(done_cpu),
        .done_err(done_err), .cmd_overflow(cmd_overflow), .timeout_err(timeout_err),
        .clear_err(clear_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        if (cpu_gnt) gnt_cnt++;
        if (done_jtag || done_cpu) done_cnt++;
        if (oci_req) req_cnt++;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_issue(input string tag);
        logic [42:0] e;
        int n;
        n = 0;
        while (!oci_req && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_req"}, 64'(oci_req), 64'd1);
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_txn"}, 64'({oci_src, oci_op, oci_data}), 64'(e));
        end
    endtask

    task automatic ack_done(input string tag, input logic src, input logic err);
        oci_ack = 1'b1;
        oci_err = err;
        tick();
        oci_ack = 1'b0;
        oci_err = 1'b0;
        check({tag, "_done"}, 64'({oci_req, done_jtag, done_cpu, done_err}),
              64'({1'b0, src == 1'b0, src == 1'b1, err}));
    endtask

    initial begin
        int hi;
        // Reset state
        tick();
        check("rst_outs", 64'({oci_req, cpu_gnt, done_jtag, done_cpu, done_err,
                               cmd_overflow, timeout_err}), 64'd0);
        tick();
        reset_n = 1'b1;
        tick();
        check("idle_no_req", 64'(oci_req), 64'd0);

        // Round robin: JTAG, CPU, JTAG, CPU
        ta = 8'h40; jdo = 38'h1_0000_0AAA;
        exp_q.push_back({1'b0, 4'd7, 38'h1_0000_0AAA});
        tick();
        ta = 8'h80; jdo = 38'h0_BEEF_0001;
        cpu_req = 1'b1; cpu_op = 4'd9; cpu_data = 38'h3_0000_C001;
        exp_q.push_back({1'b1, 4'd9, 38'h3_0000_C001});
        exp_q.push_back({1'b0, 4'd8, 38'h0_BEEF_0001});
        exp_q.push_back({1'b1, 4'd9, 38'h3_0000_C002});
        tick();
        ta = 8'h00;
        expect_issue("rr1");
        check("rr1_nogrant", 64'(cpu_gnt), 64'd0);
        ack_done("rr1", 1'b0, 1'b0);
        tick();
        expect_issue("rr2");
        check("rr2_gnt", 64'(cpu_gnt), 64'd1);
        cpu_data = 38'h3_0000_C002;
        tick();
        check("rr2_gnt_drop", 64'(cpu_gnt), 64'd0);
        ack_done("rr2", 1'b1, 1'b1);
        tick();
        expect_issue("rr3");
        ack_done("rr3", 1'b0, 1'b0);
        tick();
        expect_issue("rr4");
        cpu_req = 1'b0;
        ack_done("rr4", 1'b1, 1'b0);
        repeat (3) tick();
        check("rr_gnt_count", 64'(gnt_cnt), 64'd2);

        // Single ocimem_a, ack three cycles after issue
        ta = 8'h08; jdo = 38'h2_1234_5678;
        exp_q.push_back({1'b0, 4'd4, 38'h2_1234_5678});
        tick();
        ta = 8'h00;
        check("single_latency", 64'(oci_req), 64'd0);
        tick();
        expect_issue("single");
        hi = 1;
        repeat (3) begin
            tick();
            if (oci_req) hi++;
        end
        ack_done("single", 1'b0, 1'b0);
        check("single_req_len", 64'(hi), 64'd4);
        tick();
        check("single_done_once", 64'(done_jtag), 64'd0);

        // Six strobes back to back, no ack: one issued, four queued, one dropped
        for (int i = 0; i < 6; i++) begin
            ta = 8'(1 << i);
            jdo = 38'h0_5000_0000 + 38'(i);
            if (i < 5) exp_q.push_back({1'b0, 4'(i + 1), 38'h0_5000_0000 + 38'(i)});
            tick();
            if (i == 4) check("burst_no_ovf", 64'(cmd_overflow), 64'd0);
            if (i == 5) check("burst_ovf", 64'(cmd_overflow), 64'd1);
        end
        ta = 8'h00;
        expect_issue("burst1");
        hi = 5;
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        if (oci_req) hi++;
        check("ovf_cleared", 64'(cmd_overflow), 64'd0);
        // Watchdog abort
        for (int n = 0; n < 400 && oci_req; n++) begin
            tick();
            if (oci_req) hi++;
        end
        check("to_req_len", 64'(hi), 64'd256);
        check("to_done", 64'({done_jtag, done_err, timeout_err}), 64'b111);
        tick();
        expect_issue("burst2");
        for (int i = 0; i < 3; i++) begin
            ack_done("burst_ack", 1'b0, 1'b0);
            tick();
            expect_issue("burst_next");
        end
        ack_done("burst5", 1'b0, 1'b0);
        req_cnt = 0;
        repeat (5) tick();
        check("burst_sixth_dropped", 64'(req_cnt), 64'd0);
        check("burst_sb_drained", 64'(exp_q.size()), 64'd0);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        check("to_cleared", 64'(timeout_err), 64'd0);

        // Two strobes in one cycle: lowest opcode wins
        ta = 8'h21; jdo = 38'h0_0000_0077;
        exp_q.push_back({1'b0, 4'd1, 38'h0_0000_0077});
        tick();
        ta = 8'h00;
        check("multi_ovf", 64'(cmd_overflow), 64'd1);
        tick();
        expect_issue("multi");
        ack_done("multi", 1'b0, 1'b0);
        req_cnt = 0;
        repeat (4) tick();
        check("multi_single_entry", 64'(req_cnt), 64'd0);

        // Reset while busy with two queued
        for (int i = 0; i < 3; i++) begin
            ta = 8'h10; jdo = 38'h0_0000_0100 + 38'(i);
            tick();
        end
        ta = 8'h00;
        check("pre_rst_busy", 64'(oci_req), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        check("rst_async_req", 64'(oci_req), 64'd0);
        tick();
        check("rst_flags", 64'({cmd_overflow, timeout_err, done_jtag}), 64'd0);
        reset_n = 1'b1;
        req_cnt = 0;
        done_cnt = 0;
        repeat (10) tick();
        check("post_rst_quiet", 64'({16'(req_cnt), 16'(done_cnt)}), 64'd0);
        cpu_req = 1'b1; cpu_op = 4'd9; cpu_data = 38'h2_2222_0009;
        exp_q.push_back({1'b1, 4'd9, 38'h2_2222_0009});
        tick();
        expect_issue("post_rst_cpu");
        check("post_rst_gnt", 64'(cpu_gnt), 64'd1);
        cpu_req = 1'b0;
        ack_done("post_rst_cpu", 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
